gc_fetcher: RTL

Per-core requester for the shared global loop counter (gc) during parallel sections. The top-level gc allocator answers every request in the same cycle. This block issues those requests and buffers the granted indices in a small FIFO ahead of the core's issue stage. It detects loop exhaustion against a bound and raises `ending` once its buffered work is drained, which feeds the parent's all-children-ending join.

---
 rtl/gc_fetcher_pkg.sv | 12 +
 rtl/gc_fifo.sv | 54 +++++
 rtl/gc_fetcher.sv | 84 ++++++++
 3 files changed

// File: rtl/gc_fetcher_pkg.sv
// Shared definitions for the gc fetcher: counter width and FSM state encoding.
package gc_fetcher_pkg;

  localparam int GC_WIDTH = 16;

  typedef logic [1:0] gcf_state_t;

  localparam gcf_state_t ST_IDLE  = 2'd0;
  localparam gcf_state_t ST_FETCH = 2'd1;
  localparam gcf_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/gc_fifo.sv
// Prefetch FIFO for granted gc indices: power-of-two storage with wrapping
// pointers, an explicit occupancy count and a synchronous flush.
module gc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and count; flush clears occupancy but keeps storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gc_fetcher.sv
// Per-core gc requester: fetches loop indices from the shared allocator,
// buffers in-range grants and signals ending once exhausted and drained.
//
// state    | meaning
// ---------|------------------------------------------------------------
// ST_IDLE  | no section active, ending asserted
// ST_FETCH | requesting while FIFO has room, pushing in-range grants
// ST_DRAIN | bound reached, waiting for consumer to empty the FIFO
module gc_fetcher
  import gc_fetcher_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GC_WIDTH-1:0] limit,
  input  logic                step_neg,
  output logic                req_valid,
  input  logic                req_ready,
  input  logic [GC_WIDTH-1:0] gc,
  output logic                out_valid,
  output logic [GC_WIDTH-1:0] out_gc,
  input  logic                out_ready,
  output logic                ending
);

  gcf_state_t                  state;
  logic signed [GC_WIDTH-1:0]  limit_q;
  logic                        step_neg_q;
  logic                        full;
  logic                        empty;
  logic                        accept;
  logic                        in_range;
  logic                        push;
  logic                        pop;

  // Outputs depend only on registered state and FIFO occupancy.
  assign req_valid = (state == ST_FETCH) && !full;
  assign out_valid = !empty;
  assign ending    = (state == ST_IDLE);

  assign accept   = req_valid && req_ready;
  assign in_range = step_neg_q ? ($signed(gc) > limit_q) : ($signed(gc) < limit_q);
  // A grant arriving in the same cycle as a restart belongs to the old section.
  assign push     = accept && in_range && !start;
  assign pop      = out_valid && out_ready;

  gc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GC_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (push),
    .push_data (gc),
    .pop       (pop),
    .head      (out_gc),
    .full      (full),
    .empty     (empty)
  );

  // Section FSM; start from any state (re)loads the bound and restarts fetching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      limit_q    <= '0;
      step_neg_q <= 1'b0;
    end else if (start) begin
      state      <= ST_FETCH;
      limit_q    <= $signed(limit);
      step_neg_q <= step_neg;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_FETCH: if (accept && !in_range) state <= ST_DRAIN;
        ST_DRAIN: if (empty) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
